// File: rtl/pwm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_ctrl_pkg
//  Description : Shared definitions for the multi-channel PWM controller:
//                register word addresses, CFG/STATUS bit positions, the
//                counting-mode enum and a byte-lane merge helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_ctrl_pkg;

    // Register word addresses
    localparam logic [5:0] ADDR_PERIOD    = 6'h00;
    localparam logic [5:0] ADDR_CH_EN     = 6'h01;
    localparam logic [5:0] ADDR_CFG       = 6'h02;
    localparam logic [5:0] ADDR_STATUS    = 6'h03;
    localparam logic [5:0] ADDR_POL       = 6'h04;
    localparam logic [5:0] ADDR_DUTY_BASE = 6'h08;

    // CFG bits
    localparam int CFG_MODE_BIT   = 0;
    localparam int CFG_UPDATE_BIT = 1;
    localparam int CFG_IRQ_EN_BIT = 2;

    // STATUS bits
    localparam int STAT_DONE_BIT  = 0;
    localparam int STAT_PEND_BIT  = 1;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    // Replace the byte lanes of old_val selected by be with those of new_val.
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_ctrl_mc_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_ctrl_mc_if
//  Description : Avalon-MM slave bus bundle for pwm_ctrl_mc.
//  Signals     : read, write, chipselect, address[5:0], byteenable[3:0],
//                writedata[31:0] (master -> slave); readdata[31:0]
//                (slave -> master, fixed read latency 1).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pwm_ctrl_mc_if;
    logic        read;
    logic        write;
    logic        chipselect;
    logic [5:0]  address;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output read, write, chipselect, address, byteenable, writedata,
        input  readdata
    );

    modport slave (
        input  read, write, chipselect, address, byteenable, writedata,
        output readdata
    );
endinterface
`default_nettype wire

// File: rtl/pwm_cnt_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_cnt_gen
//  Description : PWM period counter. Edge mode counts 0..max and wraps;
//                center mode counts 0..max..0 with single-cycle turnarounds.
//                period_bound flags the last cycle of a period.
//  Ports       : clock, reset   - clock / synchronous active-high reset
//                run            - any channel enabled; counter idles at 0
//                restart        - force cnt=0, dir=up next cycle
//                mode, cnt_max  - active counting mode and terminal count
//                cnt            - current count
//                period_bound   - boundary of the current cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_cnt_gen
    import pwm_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 restart,
    input  pwm_mode_e            mode,
    input  logic [CNT_WIDTH-1:0] cnt_max,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 period_bound
);
    localparam logic c_DIR_UP   = 1'b0;
    localparam logic c_DIR_DOWN = 1'b1;

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 dir_q, dir_d;
    logic                 run_q, run_d;
    logic                 w_max_zero, w_at_max, w_at_zero;

    assign w_max_zero = (cnt_max == '0);
    assign w_at_max   = (cnt_q >= cnt_max);
    assign w_at_zero  = (cnt_q == '0);
    assign cnt        = cnt_q;

    // Boundary is kept in its own block so that logic using it to form
    // restart does not look like a loop through the next-state logic.
    always_comb begin : p_bound
        period_bound = 1'b0;
        if (run) begin
            if (w_max_zero) begin
                period_bound = 1'b1;
            end else if (mode == PWM_EDGE) begin
                period_bound = w_at_max;
            end else begin
                // run_q low means this is the first running cycle
                period_bound = (w_at_zero && dir_q == c_DIR_DOWN) || !run_q;
            end
        end
    end

    always_comb begin : p_next
        cnt_d = cnt_q;
        dir_d = dir_q;
        run_d = run;
        if (!run || restart || w_max_zero) begin
            cnt_d = '0;
            dir_d = c_DIR_UP;
        end else if (mode == PWM_EDGE) begin
            cnt_d = w_at_max ? '0 : cnt_q + 1'b1;
            dir_d = c_DIR_UP;
        end else if (dir_q == c_DIR_UP) begin
            if (w_at_max) begin
                cnt_d = cnt_max - 1'b1;
                dir_d = c_DIR_DOWN;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if (w_at_zero) begin
                cnt_d = CNT_WIDTH'(1);
                dir_d = c_DIR_UP;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            dir_q <= c_DIR_UP;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            run_q <= run_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/pwm_ctrl_mc.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_ctrl_mc
//  Description : Multi-channel PWM controller with edge/center counting,
//                per-channel polarity, shadowed period/mode/duty committed at
//                a period boundary, and a period-done interrupt.
//  Ports       : clock, reset   - clock / synchronous active-high reset
//                bus            - Avalon-MM slave (pwm_ctrl_mc_if.slave)
//                irq            - level interrupt, period_done & irq_en
//                pwm_out_ff     - registered PWM outputs [NUM_CH-1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_ctrl_mc
    import pwm_ctrl_pkg::*;
#(
    parameter int NUM_CH    = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic              clock,
    input  logic              reset,
    pwm_ctrl_mc_if.slave      bus,
    output logic              irq,
    output logic [NUM_CH-1:0] pwm_out_ff
);
    logic [CNT_WIDTH-1:0] period_sh_q, period_sh_d, period_act_q, period_act_d;
    logic [NUM_CH-1:0]    ch_en_q, ch_en_d, pol_q, pol_d;
    logic [NUM_CH-1:0]    pwm_out_ff_q, pwm_out_ff_d;
    pwm_mode_e            mode_sh_q, mode_sh_d, mode_act_q, mode_act_d;
    logic                 irq_en_q, irq_en_d, done_q, done_d, pend_q, pend_d;
    logic [CNT_WIDTH-1:0] duty_sh_q  [NUM_CH];
    logic [CNT_WIDTH-1:0] duty_sh_d  [NUM_CH];
    logic [CNT_WIDTH-1:0] duty_act_q [NUM_CH];
    logic [CNT_WIDTH-1:0] duty_act_d [NUM_CH];
    logic [31:0]          readdata_q, readdata_d;

    logic                 w_wr, w_rd, w_upd, w_w1c, w_run, w_bound, w_commit, w_restart;
    logic [CNT_WIDTH-1:0] w_cnt;
    logic [NUM_CH-1:0]    w_raw;

    assign w_wr  = bus.chipselect & bus.write;
    assign w_rd  = bus.chipselect & bus.read;
    assign w_upd = w_wr && bus.address == ADDR_CFG && bus.byteenable[0]
                   && bus.writedata[CFG_UPDATE_BIT];
    assign w_w1c = w_wr && bus.address == ADDR_STATUS && bus.byteenable[0]
                   && bus.writedata[STAT_DONE_BIT];
    assign w_run = |ch_en_q;

    // With every channel off there is no period to wait for, so a pending
    // update commits immediately.
    assign w_commit  = pend_q & (w_bound | ~w_run);
    assign w_restart = w_commit & (mode_sh_q != mode_act_q);

    pwm_cnt_gen #(
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_cnt (
        .clock        (clock),
        .reset        (reset),
        .run          (w_run),
        .restart      (w_restart),
        .mode         (mode_act_q),
        .cnt_max      (period_act_q),
        .cnt          (w_cnt),
        .period_bound (w_bound)
    );

    always_comb begin : p_regs
        period_sh_d  = period_sh_q;
        period_act_d = period_act_q;
        ch_en_d      = ch_en_q;
        pol_d        = pol_q;
        mode_sh_d    = mode_sh_q;
        mode_act_d   = mode_act_q;
        irq_en_d     = irq_en_q;
        duty_sh_d    = duty_sh_q;
        duty_act_d   = duty_act_q;
        pend_d       = pend_q;
        done_d       = done_q;

        if (w_wr) begin
            case (bus.address)
                ADDR_PERIOD: period_sh_d = CNT_WIDTH'(be_merge(32'(period_sh_q),
                                               bus.writedata, bus.byteenable));
                ADDR_CH_EN:  ch_en_d = NUM_CH'(be_merge(32'(ch_en_q),
                                               bus.writedata, bus.byteenable));
                ADDR_POL:    pol_d = NUM_CH'(be_merge(32'(pol_q),
                                               bus.writedata, bus.byteenable));
                ADDR_CFG: begin
                    if (bus.byteenable[0]) begin
                        mode_sh_d = pwm_mode_e'(bus.writedata[CFG_MODE_BIT]);
                        irq_en_d  = bus.writedata[CFG_IRQ_EN_BIT];
                    end
                end
                default: ;
            endcase
            for (int n = 0; n < NUM_CH; n++) begin
                if (bus.address == ADDR_DUTY_BASE + 6'(n)) begin
                    duty_sh_d[n] = CNT_WIDTH'(be_merge(32'(duty_sh_q[n]),
                                              bus.writedata, bus.byteenable));
                end
            end
        end

        // Commit copies the registered shadows, so a same-cycle shadow write
        // is not included and waits for the next UPDATE.
        if (w_commit) begin
            period_act_d = period_sh_q;
            mode_act_d   = mode_sh_q;
            duty_act_d   = duty_sh_q;
            pend_d       = 1'b0;
        end else if (w_upd) begin
            pend_d = 1'b1;
        end

        // A boundary set takes priority over a same-cycle W1C.
        if (w_bound) begin
            done_d = 1'b1;
        end else if (w_w1c) begin
            done_d = 1'b0;
        end
    end

    always_comb begin : p_read
        readdata_d = '0;
        if (w_rd) begin
            case (bus.address)
                ADDR_PERIOD: readdata_d = 32'(period_sh_q);
                ADDR_CH_EN:  readdata_d = 32'(ch_en_q);
                ADDR_CFG:    readdata_d = {29'b0, irq_en_q, 1'b0, mode_sh_q};
                ADDR_STATUS: readdata_d = {30'b0, pend_q, done_q};
                ADDR_POL:    readdata_d = 32'(pol_q);
                default: ;
            endcase
            for (int n = 0; n < NUM_CH; n++) begin
                if (bus.address == ADDR_DUTY_BASE + 6'(n)) begin
                    readdata_d = 32'(duty_sh_q[n]);
                end
            end
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_cmp
        assign w_raw[n] = ch_en_q[n] & (w_cnt < duty_act_q[n]);
    end
    assign pwm_out_ff_d = w_raw ^ pol_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            period_sh_q  <= '1;
            period_act_q <= '1;
            ch_en_q      <= '0;
            pol_q        <= '0;
            mode_sh_q    <= PWM_EDGE;
            mode_act_q   <= PWM_EDGE;
            irq_en_q     <= 1'b0;
            pend_q       <= 1'b0;
            done_q       <= 1'b0;
            readdata_q   <= '0;
            pwm_out_ff_q <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                duty_sh_q[n]  <= '0;
                duty_act_q[n] <= '0;
            end
        end else begin
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            ch_en_q      <= ch_en_d;
            pol_q        <= pol_d;
            mode_sh_q    <= mode_sh_d;
            mode_act_q   <= mode_act_d;
            irq_en_q     <= irq_en_d;
            pend_q       <= pend_d;
            done_q       <= done_d;
            readdata_q   <= readdata_d;
            pwm_out_ff_q <= pwm_out_ff_d;
            duty_sh_q    <= duty_sh_d;
            duty_act_q   <= duty_act_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign pwm_out_ff   = pwm_out_ff_q;
    assign irq          = done_q & irq_en_q;
endmodule
`default_nettype wire

// File: tb/tb_pwm_ctrl_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_ctrl_mc
//  Description : Directed self-checking bench for pwm_ctrl_mc. Bus reads and
//                the center-mode waveform go through an expected-value queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_ctrl_mc;
    import pwm_ctrl_pkg::*;

    localparam int NUM_CH    = 8;
    localparam int CNT_WIDTH = 16;
    localparam int LIMIT     = 200;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              irq;
    logic [NUM_CH-1:0] pwm_out_ff;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q [$];

    pwm_ctrl_mc_if bus_if ();

    pwm_ctrl_mc #(
        .NUM_CH     (NUM_CH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus_if),
        .irq        (irq),
        .pwm_out_ff (pwm_out_ff)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clock);
        bus_if.chipselect = 1'b1;
        bus_if.write      = 1'b1;
        bus_if.address    = a;
        bus_if.writedata  = d;
        bus_if.byteenable = be;
        @(negedge clock);
        bus_if.chipselect = 1'b0;
        bus_if.write      = 1'b0;
        bus_if.byteenable = 4'h0;
    endtask

    task automatic bus_read(input logic [5:0] a, input logic [31:0] expv, input string tag);
        @(negedge clock);
        bus_if.chipselect = 1'b1;
        bus_if.read       = 1'b1;
        bus_if.address    = a;
        exp_q.push_back(expv);
        @(negedge clock);
        bus_if.chipselect = 1'b0;
        bus_if.read       = 1'b0;
        check(tag, bus_if.readdata, exp_q.pop_front());
    endtask

    // Returns at the first negedge where pwm_out_ff[ch] is seen rising.
    task automatic wait_rise(input int ch, input string tag);
        int   n;
        bit   found;
        logic prev;
        n     = 0;
        found = 1'b0;
        prev  = pwm_out_ff[ch];
        while (!found && n < LIMIT) begin
            @(negedge clock);
            n++;
            found = pwm_out_ff[ch] && !prev;
            prev  = pwm_out_ff[ch];
        end
        check({tag, "_rise_found"}, 32'(found), 32'd1);
    endtask

    task automatic wait_irq(output int n);
        n = 0;
        while (!irq && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic count_high(input int ch, input int ncyc, output int hi);
        hi = 0;
        repeat (ncyc) begin
            @(negedge clock);
            if (pwm_out_ff[ch]) hi++;
        end
    endtask

    initial begin
        int hi;
        int n;
        bus_if.read       = 1'b0;
        bus_if.write      = 1'b0;
        bus_if.chipselect = 1'b0;
        bus_if.address    = '0;
        bus_if.byteenable = '0;
        bus_if.writedata  = '0;

        // ---- reset state
        idle(3);
        reset = 1'b0;
        check("rst_pwm", 32'(pwm_out_ff), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        bus_read(ADDR_PERIOD, 32'h0000_FFFF, "rst_period");
        bus_read(ADDR_CH_EN,  32'h0, "rst_ch_en");
        bus_read(ADDR_CFG,    32'h0, "rst_cfg");
        bus_read(ADDR_STATUS, 32'h0, "rst_status");
        bus_read(ADDR_POL,    32'h0, "rst_pol");
        bus_read(ADDR_DUTY_BASE, 32'h0, "rst_duty0");

        // ---- bus: byte lanes, unmapped address, idle readdata
        bus_write(ADDR_PERIOD, 32'h1234_5678, 4'h1);
        bus_read(ADDR_PERIOD, 32'h0000_FF78, "be_period");
        bus_write(6'h3F, 32'hFFFF_FFFF, 4'hF);
        bus_read(6'h3F, 32'h0, "unmapped_read");
        check("idle_readdata", bus_if.readdata, 32'h0);

        // ---- edge mode: max=9, duty=3 -> 3 high of every 10
        bus_write(ADDR_PERIOD, 32'd9, 4'hF);
        bus_write(ADDR_DUTY_BASE, 32'd3, 4'hF);
        bus_write(ADDR_CFG, 32'h2, 4'hF);
        bus_read(ADDR_STATUS, 32'h0, "idle_commit_no_wait");
        bus_read(ADDR_CFG, 32'h0, "update_reads_0");
        bus_write(ADDR_CH_EN, 32'h1, 4'hF);
        idle(2);
        count_high(0, 10, hi);
        check("edge_high_10", 32'(hi), 32'd3);
        count_high(0, 20, hi);
        check("edge_high_20", 32'(hi), 32'd6);

        // ---- interrupt. Rise seen at N means cnt==1 at N, so cnt==9 at N+8.
        bus_write(ADDR_CFG, 32'h4, 4'hF);
        wait_rise(0, "irq_phase");
        idle(7);
        bus_write(ADDR_STATUS, 32'h1, 4'hF);        // W1C lands on the boundary
        check("w1c_at_bound_irq", 32'(irq), 32'd1);
        for (int k = 0; k < 2; k++) begin
            bus_write(ADDR_STATUS, 32'h1, 4'hF);    // W1C away from a boundary
            check("w1c_clears_irq", 32'(irq), 32'd0);
            wait_irq(n);
            check("irq_next_bound", 32'(n), 32'd8);
        end

        // ---- shadow commit mid-period
        wait_rise(0, "shadow_phase");               // cnt==1
        bus_write(ADDR_DUTY_BASE, 32'd7, 4'hF);
        bus_write(ADDR_CFG, 32'h2, 4'hF);
        bus_read(ADDR_STATUS, 32'h3, "pending_set");
        check("old_duty_holds", 32'(pwm_out_ff[0]), 32'd0);  // reflects cnt==6
        wait_rise(0, "shadow_commit");
        count_high(0, 10, hi);
        check("new_duty_high", 32'(hi), 32'd7);
        bus_read(ADDR_STATUS, 32'h1, "pending_clear");

        // ---- duty extremes, polarity, disabled channel
        bus_write(ADDR_DUTY_BASE, 32'd0, 4'hF);
        bus_write(ADDR_CFG, 32'h2, 4'hF);
        idle(15);
        count_high(0, 10, hi);
        check("duty0_const0", 32'(hi), 32'd0);
        bus_write(ADDR_DUTY_BASE, 32'hFFFF, 4'hF);
        bus_write(ADDR_CFG, 32'h2, 4'hF);
        idle(15);
        count_high(0, 10, hi);
        check("dutymax_const1", 32'(hi), 32'd10);
        bus_write(ADDR_POL, 32'h1, 4'hF);
        idle(2);
        count_high(0, 10, hi);
        check("pol_inverts", 32'(hi), 32'd0);
        bus_write(ADDR_CH_EN, 32'h0, 4'hF);
        idle(2);
        count_high(0, 10, hi);
        check("disabled_idles_pol", 32'(hi), 32'd10);

        // ---- center mode: max=4, duty[1]=2. cnt runs 0,1,2,3,4,3,2,1 so
        // cnt<2 holds on 3 of 8 cycles, centred on cnt==0.
        bus_write(ADDR_PERIOD, 32'd4, 4'hF);
        bus_write(ADDR_DUTY_BASE + 6'd1, 32'd2, 4'hF);
        bus_write(ADDR_CFG, 32'h3, 4'hF);
        bus_write(ADDR_CH_EN, 32'h2, 4'hF);
        idle(10);
        wait_rise(1, "center_phase");               // cnt==0 going down now
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(((i % 8) == 0 || (i % 8) == 1 || (i % 8) == 7) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            check($sformatf("center_wave_%0d", i), 32'(pwm_out_ff[1]), exp_q.pop_front());
        end
        check("center_ch0_pol", 32'(pwm_out_ff[0]), 32'd1);
        bus_write(ADDR_CFG, 32'h5, 4'hF);
        check("center_irq", 32'(irq), 32'd1);
        bus_read(ADDR_CFG, 32'h5, "cfg_readback");

        // ---- reset mid-period
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_pwm", 32'(pwm_out_ff), 32'h0);
        check("midrst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        bus_read(ADDR_PERIOD, 32'h0000_FFFF, "midrst_period");
        bus_read(ADDR_CH_EN,  32'h0, "midrst_ch_en");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
